// File: rtl/hex_select_ctrl.sv
// hex_select_ctrl: pushbutton-driven page select for the 7-segment display path.
// A two-flop synchroniser feeds a debounce FSM. Each accepted press advances
// the 2-bit page select (0..3, wrapping) and emits a one-cycle step pulse.
// The selected 8-bit source is registered into a snapshot that holds while
// freeze is high.
// Optional feature macro: HEX_AUTOSCROLL_EN. When it is defined, a free-running
// SCROLL_DIV counter also advances the page while the key is idle and the
// display is not frozen.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | key released and stable; waiting for key_s to go low
// PRESS_WAIT   | key low; counting stable-low cycles before accepting
// HELD         | press accepted; holding the key does not repeat
// RELEASE_WAIT | key high; counting stable-high cycles before re-arming
module hex_select_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEBOUNCE   = 50000,
  parameter int unsigned SCROLL_DIV = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_n,
  input  logic       freeze,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  output logic [1:0] select,
  output logic [7:0] value,
  output logic       step
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } state_t;

  // The last count value before acceptance; the counter never moves past it.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             key_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             scroll_adv;
  logic             advance;
  logic [1:0]       select_q, select_d;
  logic [7:0]       value_q, value_d;
  logic             step_q, step_d;

  // Two-flop synchroniser; resets to the released level so reset never looks like a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign key_s = sync2_q;

  // FSM state and debounce counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Debounce next-state logic; accept marks the edge where a press is taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!key_s) begin
          cnt_d   = '0;
          state_d = ST_PRESS_WAIT;
        end
      end
      ST_PRESS_WAIT: begin
        if (key_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_HELD;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (key_s) begin
          cnt_d   = '0;
          state_d = ST_RELEASE_WAIT;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = ST_HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef HEX_AUTOSCROLL_EN
  localparam int unsigned SCR_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [SCR_W-1:0] SCR_MAX = SCR_W'(SCROLL_DIV - 1);

  logic [SCR_W-1:0] scr_q, scr_d;
  logic             tick;

  // Scroll period counter; a press restarts the period so the user gets a full dwell.
  always_comb begin
    tick       = (scr_q == SCR_MAX);
    scroll_adv = tick && (state_q == ST_IDLE) && !freeze;
    if (accept || tick) begin
      scr_d = '0;
    end else begin
      scr_d = scr_q + 1'b1;
    end
  end

  // Scroll counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scr_q <= '0;
    end else begin
      scr_q <= scr_d;
    end
  end
`else
  localparam int unsigned unused_scroll_div = SCROLL_DIV;
  assign scroll_adv = 1'b0;
`endif

  // Page advance and snapshot mux. A tick and a press can never both advance:
  // a tick only counts in IDLE and a press is only accepted in PRESS_WAIT.
  always_comb begin
    advance  = accept | scroll_adv;
    select_d = select_q + {1'b0, advance};
    step_d   = advance;
    value_d  = value_q;
    if (!freeze) begin
      case (select_d)
        2'd0:    value_d = in0;
        2'd1:    value_d = in1;
        2'd2:    value_d = in2;
        default: value_d = in3;
      endcase
    end
  end

  // Output registers; nothing combinational reaches the ports.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      select_q <= 2'd0;
      value_q  <= 8'h00;
      step_q   <= 1'b0;
    end else begin
      select_q <= select_d;
      value_q  <= value_d;
      step_q   <= step_d;
    end
  end

  assign select = select_q;
  assign value  = value_q;
  assign step   = step_q;

endmodule

// File: tb/tb_hex_select_ctrl.sv
// Bench for hex_select_ctrl with DEBOUNCE=4 and SCROLL_DIV=8. A page-level
// model runs alongside the DUT and is compared every cycle; directed literal
// checks pin the model at the points worked out by hand.
module tb_hex_select_ctrl;

  localparam int DEB = 4;
  localparam int SCR = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       key_n = 1'b1;
  logic       freeze = 1'b0;
  logic [7:0] in0 = 8'h00;
  logic [7:0] in1 = 8'hA5;
  logic [7:0] in2 = 8'h22;
  logic [7:0] in3 = 8'h33;
  logic [1:0] select;
  logic [7:0] value;
  logic       step;

  int n_pass = 0;
  int n_total = 0;

  hex_select_ctrl #(.CNT_W(16), .DEBOUNCE(DEB), .SCROLL_DIV(SCR)) dut (
    .clock  (clock),
    .reset  (reset),
    .key_n  (key_n),
    .freeze (freeze),
    .in0    (in0),
    .in1    (in1),
    .in2    (in2),
    .in3    (in3),
    .select (select),
    .value  (value),
    .step   (step)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model: the key is seen two cycles late; a press is taken when the
  // synchronised key has been low for DEB+1 consecutive samples while
  // released, and the release completes after DEB+1 consecutive highs.
  bit kd1, kd2, last_ks, m_held;
  int run, n_scr;
  int m_sel, m_val, m_step;

  function automatic int pick(input int s);
    case (s)
      0: return int'(in0);
      1: return int'(in1);
      2: return int'(in2);
      default: return int'(in3);
    endcase
  endfunction

  task automatic model_reset();
    kd1 = 1'b1; kd2 = 1'b1; last_ks = 1'b1; m_held = 1'b0;
    run = 1000; n_scr = 0;
    m_sel = 0; m_val = 0; m_step = 0;
  endtask

  task automatic model_step();
    bit ks, idle, acc;
    int adv;
    ks = kd2; kd2 = kd1; kd1 = key_n;
    idle = !m_held && last_ks;
    if (ks == last_ks) begin
      if (run < 1000) run++;
    end else begin
      run = 1;
    end
    acc = 1'b0;
    if (!m_held && !ks && run == DEB + 1) begin
      acc = 1'b1;
      m_held = 1'b1;
    end else if (m_held && ks && run == DEB + 1) begin
      m_held = 1'b0;
    end
    last_ks = ks;
    adv = acc ? 1 : 0;
`ifdef HEX_AUTOSCROLL_EN
    n_scr++;
    if ((n_scr % SCR == 0) && idle && !freeze) adv = 1;
    if (acc) n_scr = 0;
`else
    if (idle && n_scr < 0) adv = 1;
`endif
    m_sel = (m_sel + adv) % 4;
    m_step = adv;
    if (!freeze) m_val = pick(m_sel);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("model_select", int'(select), m_sel);
        chk("model_value", int'(value), m_val);
        chk("model_step", int'(step), m_step);
      end
    end
  end

  task automatic press(input int lo, input int hi);
    key_n = 1'b0;
    repeat (lo) @(negedge clock);
    key_n = 1'b1;
    repeat (hi) @(negedge clock);
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] wrap_val [4];
    wrap_val[0] = 8'h11; wrap_val[1] = 8'h22; wrap_val[2] = 8'h33; wrap_val[3] = 8'h00;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("reset_select", int'(select), 0);
    chk("reset_value", int'(value), 8'h00);
    chk("reset_step", int'(step), 0);

`ifdef HEX_AUTOSCROLL_EN
    repeat (6) @(posedge clock); #1;
    chk("scroll_no_step_early", int'(step), 0);
    @(posedge clock); #1;
    chk("scroll_first_step", int'(step), 1);
    chk("scroll_first_select", int'(select), 1);
    repeat (8) @(posedge clock); #1;
    chk("scroll_second_select", int'(select), 2);
    @(negedge clock);
    key_n = 1'b0;
    repeat (40) @(negedge clock);
    chk("held_no_scroll", int'(select), 3);
    key_n = 1'b1;
    repeat (30) @(negedge clock);
`else
    // Clean press: step exactly 2+1+4 edges after the key falls.
    @(negedge clock);
    key_n = 1'b0;
    repeat (6) @(posedge clock); #1;
    chk("press_no_step_early", int'(step), 0);
    @(posedge clock); #1;
    chk("press_step", int'(step), 1);
    chk("press_select", int'(select), 1);
    chk("press_value", int'(value), 8'hA5);
    @(posedge clock); #1;
    chk("press_step_single", int'(step), 0);
    repeat (3) @(negedge clock);
    key_n = 1'b1;
    repeat (10) @(negedge clock);

    // Reset in the middle of PRESS_WAIT.
    key_n = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_select", int'(select), 0);
    chk("async_reset_value", int'(value), 8'h00);
    chk("async_reset_step", int'(step), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(posedge clock); #1;
    chk("post_reset_no_step", int'(step), 0);
    @(posedge clock); #1;
    chk("post_reset_step", int'(step), 1);
    chk("post_reset_select", int'(select), 1);
    @(negedge clock);
    key_n = 1'b1;
    repeat (10) @(negedge clock);

    // Bounce: 3 low, 1 high, 2 low is rejected; a 6-cycle low is accepted.
    press(3, 1);
    press(2, 10);
    chk("bounce_rejected", int'(select), 1);
    press(6, 10);
    chk("long_low_select", int'(select), 2);
    chk("long_low_value", int'(value), 8'h22);

    // Wrap from reset.
    pulse_reset();
    in1 = 8'h11;
    for (int i = 0; i < 4; i++) begin
      press(8, 10);
      chk("wrap_select", int'(select), (i + 1) % 4);
      chk("wrap_value", int'(value), int'(wrap_val[i]));
    end

    // Freeze holds the snapshot while select keeps moving.
    in0 = 8'h5A;
    repeat (2) @(negedge clock);
    chk("live_value", int'(value), 8'h5A);
    freeze = 1'b1;
    in0 = 8'hC3;
    repeat (3) @(negedge clock);
    chk("frozen_value", int'(value), 8'h5A);
    press(8, 10);
    chk("frozen_press_select", int'(select), 1);
    chk("frozen_press_value", int'(value), 8'h5A);
    freeze = 1'b0;
    @(posedge clock); #1;
    chk("unfreeze_value", int'(value), 8'h11);
    @(negedge clock);
`endif

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hex_select_ctrl.md
Name: hex_select_ctrl

Overview:
- Upstream control stage for the 7-segment display path on the multicycle processor board.
- Debounces a board pushbutton and advances a 2-bit page select through values 0..3, wrapping after 3.
- Registers a stable 8-bit snapshot of the selected processor value and feeds the downstream chooser/decoder.
- The snapshot holds while `freeze` is asserted, so a running processor does not make the digits flicker.

Parameters:
- CNT_W, 16: width of the debounce counter.
- DEBOUNCE, 50000: consecutive stable cycles required to accept a press or a release. Legal range is 1..2^CNT_W-1.
- SCROLL_DIV, 25000000: auto-scroll period in cycles. Used only when HEX_AUTOSCROLL_EN is defined.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- key_n  in  1  raw pushbutton, active-low, asynchronous to clock.
- freeze  in  1  1 = hold the current snapshot; 0 = track live.
- in0  in  8  page 0 source value.
- in1  in  8  page 1 source value.
- in2  in  8  page 2 source value.
- in3  in  8  page 3 source value.
- select  out  2  current page; drives the downstream select.
- value  out  8  registered snapshot of the selected page.
- step  out  1  single-cycle pulse when select advances.

Behaviour:
- Reset: asserting reset at any time, including mid-debounce, immediately forces:
  - select=0, value=8'h00, step=0;
  - sync flops=1 (released);
  - debounce counter=0;
  - FSM=IDLE.
- Synchroniser: key_n passes through 2 flops to give key_s. Raw-to-FSM latency is 2 cycles. No other logic samples key_n directly.
- FSM states and transitions:
  - IDLE: if key_s=0, clear the counter and go to PRESS_WAIT.
  - PRESS_WAIT: count while key_s=0. If key_s=1 before the count completes, go to IDLE (glitch rejected; no step). When the counter reaches DEBOUNCE-1 with key_s still 0, go to HELD. On that same transition edge:
    - step=1;
    - select <= select+1, modulo 4 (3 wraps to 0).
  - HELD: stay while key_s=0; holding the key never repeats. If key_s=1, clear the counter and go to RELEASE_WAIT.
  - RELEASE_WAIT: count while key_s=1. If key_s=0 first, go back to HELD (bounce; no step). When the counter reaches DEBOUNCE-1 with key_s=1, go to IDLE.
- step: high for exactly one cycle per accepted press; zero in all other cycles.
- Snapshot:
  - Each cycle with freeze=0: value <= in[select_next], where select_next is the select value being loaded on that edge. After a step, value therefore shows the new page's data in the same cycle that select changes.
  - freeze=1: value holds.
  - freeze=1 during a step: select still advances, value holds. Releasing freeze loads the new page on the next edge.
- Counter: saturates at DEBOUNCE-1 and never wraps. Width rules are unsigned, CNT_W bits.
- DEBOUNCE=1: the press is accepted on the first cycle key_s is seen low in PRESS_WAIT, i.e. 1 cycle after IDLE detects it.
- Outputs are fully registered; there is no combinational path from any input to any output.

Optional Feature:
- Macro: HEX_AUTOSCROLL_EN.
- When defined:
  - A free-running SCROLL_DIV counter, reset to 0, produces a tick every SCROLL_DIV cycles.
  - The tick advances select (same wrap rule) and pulses step, but only when FSM=IDLE and freeze=0.
  - Any accepted key press clears the scroll counter.
  - If a tick and a press acceptance land in the same cycle, select advances by exactly 1.
- When undefined: no scroll logic, and select changes only on accepted presses.

Test Plan:
- Reset with DEBOUNCE=4: assert reset mid-PRESS_WAIT with key_n=0 → select=0, value=00, step=0 immediately (asynchronous). After release, a full 4-cycle low is still needed for a step.
- Clean press with DEBOUNCE=4, in1=8'hA5: key_n low for 10 cycles → exactly one step pulse, 2+1+4 cycles after the falling edge; select=1 and value=A5 on the same edge.
- Bounce: key_n low 3 cycles, high 1, low 2, then high → no step, select unchanged. A later low of 6 cycles produces one step.
- Wrap: four accepted presses from reset → select sequence 1,2,3,0; value tracks in1,in2,in3,in0 (e.g. 11,22,33,00).
- Freeze: freeze=1, change in0 from 8'h5A to 8'hC3 → value stays 5A; press → select=1, value still 5A. Deassert freeze → value=in1 on the next edge.
- HEX_AUTOSCROLL_EN with SCROLL_DIV=8, key idle → select increments every 8 cycles, each with a 1-cycle step. Hold the key (HELD) → no auto-advance until the release completes.
